keypad_scanner: RTL and testbench
=================================

Name: keypad_scanner

Overview:
- 4x4 matrix keypad scanner and debouncer for the electric piano.
- Drives the keypad rows, samples the columns and debounces the result.
- Presents a 16-bit active-high key vector, the same key_out format the beeper/tone path consumes.
- Sits between the keypad pins and the beeper/tone logic; one clock domain.

Parameters:
SCAN_DIV, 12000, clk_in cycles per row slot (1 ms at 12 MHz); minimum 4
DEBOUNCE_CNT, 4, consecutive identical full scans required before key_out updates; minimum 1

Ports:
clk_in  input  1  system clock
rst_in  input  1  synchronous, active-high reset
col_in  input  4  keypad columns, active-low (pulled up externally), asynchronous to clk_in
row_out  output  4  keypad row drive, active-low, exactly one bit low at any time
key_out  output  16  debounced key state, bit n high = key n pressed; n = row*4 + col
key_valid  output  1  one-cycle pulse when key_out changes value

Behaviour:
- col_in passes through a 2-flop synchronizer; all sampling uses the synchronized value.
- Scan FSM states: ROW0, ROW1, ROW2, ROW3. row_out is 1110, 1101, 1011 and 0111 respectively.
- Slot counter runs 0..SCAN_DIV-1. On the terminal count:
  - latch ~col_sync into raw[row*4 +: 4];
  - advance to the next state; ROW3 wraps to ROW0;
  - clear the slot counter.
- Full-scan end = terminal count in ROW3. That cycle's raw vector is the complete scan (including row 3 bits just latched) and is compared with prev_raw:
  - If equal: agree_cnt = min(agree_cnt+1, DEBOUNCE_CNT).
  - Else: agree_cnt = 1.
  - prev_raw <= scan vector.
- Commit condition: (updated agree_cnt == DEBOUNCE_CNT) and (filtered scan vector != key_out).
  - The cycle after the full-scan end: key_out <= filtered vector and key_valid = 1 for exactly one cycle.
  - Otherwise key_valid = 0.
- Latency:
  - A press that is stable from the start of a scan is reported DEBOUNCE_CNT full scans later, plus 1 cycle.
  - That is DEBOUNCE_CNT*4*SCAN_DIV + 1 cycles after that scan began.
- Any vector change between scans restarts agreement. A contact bouncing on every scan never commits.
- Idle keypad: raw = 0 = key_out, so no key_valid pulses occur.
- Reset (synchronous, any time including mid-slot):
  - row_out = 1110, state ROW0;
  - slot counter = 0, raw = 0, prev_raw = 0, agree_cnt = 0;
  - key_out = 16'h0000, key_valid = 0.
  - The first sample after reset occurs SCAN_DIV cycles after rst_in deasserts.
- Simultaneous keys: all pressed bits are reported, unless the optional feature is enabled.
- Counter widths are sized with $clog2 from the parameters. No wrap occurs beyond the stated terminal counts.

Optional Feature:
- Macro KEYPAD_ONEHOT_EN.
- Defined: the filtered vector keeps only the lowest-index set bit of the scan vector, so key_out is one-hot or zero. This is intended for tone logic that expects a single key.
  - Comparison and commit use the filtered vector.
  - Debounce agreement still uses the unfiltered vector.
- Undefined: the filtered vector equals the scan vector; multiple simultaneous keys are all reported.

Test Plan:
All scenarios use SCAN_DIV=4, DEBOUNCE_CNT=3.
- Row sequencing: release reset, hold col_in=1111 -> row_out steps 1110, 1101, 1011, 0111, 1110 every 4 cycles; key_out stays 0x0000; key_valid never asserts.
- Single press: pull col1 low whenever row_out=1101 (key 5) from the first scan -> key_out=0x0020 after 3 full scans (48 cycles + 1); key_valid pulses exactly once. Release -> key_out=0x0000 3 scans later with one key_valid pulse.
- Bounce: press key 5 on alternate scans for 10 scans -> key_out remains 0x0000; no key_valid pulse.
- Multi-key: hold keys 0 and 15 -> key_out=0x8001 without KEYPAD_ONEHOT_EN and 0x0001 with it; one key_valid pulse in each build.
- Reset mid-operation: key_out=0x0020; assert rst_in for 1 cycle during slot count 2 of ROW2 -> next cycle row_out=1110, key_out=0x0000, key_valid=0. With key 5 still held, key_out returns to 0x0020 after 3 further full scans.
- Key change without release: key 5 committed, then switch to key 6 -> key_out goes directly 0x0020 -> 0x0040 after 3 scans, with a single key_valid pulse.

Source files
------------

// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x4 keypad row scanner with debounced 16-bit key vector
// Define KEYPAD_ONEHOT_EN to report only the lowest-index pressed key.
module keypad_scanner #(
  parameter int SCAN_DIV     = 12000,
  parameter int DEBOUNCE_CNT = 4
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [3:0]  col_in,
  output logic [3:0]  row_out,
  output logic [15:0] key_out,
  output logic        key_valid
);

  localparam int SW = $clog2(SCAN_DIV);
  localparam int AW = $clog2(DEBOUNCE_CNT + 1);
  localparam logic [SW-1:0] SLOT_LAST = SW'(SCAN_DIV - 1);
  localparam logic [AW-1:0] AGREE_MAX = AW'(DEBOUNCE_CNT);

  typedef enum logic [1:0] {ROW0, ROW1, ROW2, ROW3} state_t;

  state_t        state;
  state_t        state_next;
  logic [3:0]    col_meta;
  logic [3:0]    col_sync;
  logic [SW-1:0] slot_cnt;
  logic [15:0]   raw;
  logic [15:0]   prev_raw;
  logic [15:0]   scan_vec;
  logic [15:0]   filt_vec;
  logic [15:0]   commit_vec;
  logic [AW-1:0] agree_cnt;
  logic [AW-1:0] agree_next;
  logic          slot_done;
  logic          scan_done;
  logic          commit_pend;

  assign slot_done = (slot_cnt == SLOT_LAST);
  assign scan_done = slot_done && (state == ROW3);

  always_comb begin
    state_next = state;
    row_out    = 4'b1110;
    case (state)
      ROW0: begin
        row_out = 4'b1110;
        if (slot_done) state_next = ROW1;
      end
      ROW1: begin
        row_out = 4'b1101;
        if (slot_done) state_next = ROW2;
      end
      ROW2: begin
        row_out = 4'b1011;
        if (slot_done) state_next = ROW3;
      end
      ROW3: begin
        row_out = 4'b0111;
        if (slot_done) state_next = ROW0;
      end
      default: state_next = ROW0;
    endcase
  end

  // The complete scan includes the row-3 columns being latched this very cycle.
  always_comb begin
    scan_vec        = raw;
    scan_vec[15:12] = ~col_sync;
    agree_next      = AW'(1);
    if (scan_vec == prev_raw) begin
      agree_next = (agree_cnt == AGREE_MAX) ? agree_cnt : agree_cnt + AW'(1);
    end
`ifdef KEYPAD_ONEHOT_EN
    filt_vec = scan_vec & (~scan_vec + 16'd1);
`else
    filt_vec = scan_vec;
`endif
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      col_meta    <= 4'hF;
      col_sync    <= 4'hF;
      state       <= ROW0;
      slot_cnt    <= '0;
      raw         <= '0;
      prev_raw    <= '0;
      agree_cnt   <= '0;
      commit_pend <= 1'b0;
      commit_vec  <= '0;
      key_out     <= '0;
      key_valid   <= 1'b0;
    end else begin
      col_meta    <= col_in;
      col_sync    <= col_meta;
      state       <= state_next;
      key_valid   <= commit_pend;
      commit_pend <= 1'b0;
      if (commit_pend) key_out <= commit_vec;
      if (slot_done) begin
        slot_cnt                   <= '0;
        raw[{state, 2'b00} +: 4]   <= ~col_sync;
      end else begin
        slot_cnt <= slot_cnt + SW'(1);
      end
      if (scan_done) begin
        prev_raw    <= scan_vec;
        agree_cnt   <= agree_next;
        commit_pend <= (agree_next == AGREE_MAX) && (filt_vec != key_out);
        commit_vec  <= filt_vec;
      end
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb/tb_keypad_scanner.sv - randomized self-checking bench for keypad_scanner
// Define KEYPAD_ONEHOT_EN to check the single-key build.
module tb_keypad_scanner;

  localparam int DIV  = 4;
  localparam int DEB  = 3;
  localparam int SCAN = 4 * DIV;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  col;
  logic [3:0]  row;
  logic [15:0] key_out;
  logic        key_valid;
  logic [15:0] pressed;

  int          tests;
  int          fails;
  int          cyc;
  int          pulses;
  int          seq_err;
  int          row_err;
  int          first_change;
  logic [15:0] prev_key;

  logic [15:0] hist[$];
  logic [15:0] model_key;
  int          model_pulses;

  always #5 clk = ~clk;

  keypad_scanner #(.SCAN_DIV(DIV), .DEBOUNCE_CNT(DEB)) dut (
    .clk_in   (clk),
    .rst_in   (rst),
    .col_in   (col),
    .row_out  (row),
    .key_out  (key_out),
    .key_valid(key_valid)
  );

  // Physical keypad: a pressed key shorts its row line to its column line.
  function automatic logic [3:0] drive_cols(input logic [3:0] rows, input logic [15:0] keys);
    logic [3:0] c;
    c = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int k = 0; k < 4; k++)
        if (!rows[r] && keys[r*4+k]) c[k] = 1'b0;
    return c;
  endfunction

  assign col = drive_cols(row, pressed);

  function automatic logic [15:0] expect_filter(input logic [15:0] v);
`ifdef KEYPAD_ONEHOT_EN
    for (int i = 0; i < 16; i++)
      if (v[i]) return 16'd1 << i;
    return 16'h0000;
`else
    return v;
`endif
  endfunction

  // Reference: key_out follows a scan vector once DEB consecutive scans agree on it.
  task automatic model_scan(input logic [15:0] v);
    logic all_eq;
    hist.push_back(v);
    if (hist.size() > DEB) void'(hist.pop_front());
    all_eq = (hist.size() == DEB);
    foreach (hist[i]) if (hist[i] !== v) all_eq = 1'b0;
    if (all_eq && expect_filter(v) !== model_key) begin
      model_key = expect_filter(v);
      model_pulses++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    cyc++;
    if (!rst) begin
      if (key_valid) pulses++;
      if (key_valid !== (key_out !== prev_key)) seq_err++;
      if (row !== ~(4'b0001 << ((cyc / DIV) % 4))) row_err++;
      if (key_out !== prev_key && first_change == 0) first_change = cyc;
    end
    prev_key = key_out;
  endtask

  task automatic release_reset();
    rst = 1'b0;
    hist.delete();
    model_key    = 16'h0000;
    cyc          = 0;
    first_change = 0;
    tick();
  endtask

  task automatic run_scan(input logic [15:0] v);
    pressed = v;
    repeat (SCAN) tick();
    model_scan(v);
  endtask

  task automatic test_reset();
    pressed = 16'h0000;
    rst = 1'b1;
    repeat (3) tick();
    tests++; if (row !== 4'b1110) begin fails++; $display("FAIL reset_row: row_out=%b expected=%b", row, 4'b1110); end
    tests++; if (key_out !== 16'h0000) begin fails++; $display("FAIL reset_key: key_out=%h expected=%h", key_out, 16'h0000); end
    tests++; if (key_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: key_valid=%b expected=0", key_valid); end
    release_reset();
  endtask

  task automatic test_row_sequence();
    int p0, r0;
    p0 = pulses;
    r0 = row_err;
    run_scan(16'h0000);
    run_scan(16'h0000);
    tests++; if (row_err !== r0) begin fails++; $display("FAIL row_seq: bad row cycles=%0d expected=0", row_err - r0); end
    tests++; if (pulses !== p0) begin fails++; $display("FAIL idle_pulses: pulses=%0d expected=0", pulses - p0); end
    tests++; if (key_out !== 16'h0000) begin fails++; $display("FAIL idle_key: key_out=%h expected=%h", key_out, 16'h0000); end
  endtask

  task automatic test_single_press();
    int p0;
    rst = 1'b1;
    tick();
    release_reset();
    p0 = pulses;
    run_scan(16'h0020);
    run_scan(16'h0020);
    tests++; if (key_out !== 16'h0000) begin fails++; $display("FAIL press_early: key_out=%h expected=%h", key_out, 16'h0000); end
    run_scan(16'h0020);
    tests++; if (key_out !== 16'h0020) begin fails++; $display("FAIL press_commit: key_out=%h expected=%h", key_out, 16'h0020); end
    tests++; if (first_change !== DEB * SCAN + 1) begin fails++; $display("FAIL press_latency: cycles=%0d expected=%0d", first_change, DEB * SCAN + 1); end
    run_scan(16'h0020);
    run_scan(16'h0020);
    tests++; if (pulses - p0 !== 1) begin fails++; $display("FAIL press_pulses: pulses=%0d expected=1", pulses - p0); end
    run_scan(16'h0000);
    run_scan(16'h0000);
    tests++; if (key_out !== 16'h0020) begin fails++; $display("FAIL release_early: key_out=%h expected=%h", key_out, 16'h0020); end
    run_scan(16'h0000);
    tests++; if (key_out !== 16'h0000) begin fails++; $display("FAIL release_commit: key_out=%h expected=%h", key_out, 16'h0000); end
    tests++; if (pulses - p0 !== 2) begin fails++; $display("FAIL release_pulses: pulses=%0d expected=2", pulses - p0); end
  endtask

  task automatic test_bounce();
    int p0;
    p0 = pulses;
    for (int i = 0; i < 10; i++) run_scan((i % 2 == 0) ? 16'h0020 : 16'h0000);
    tests++; if (key_out !== 16'h0000) begin fails++; $display("FAIL bounce_key: key_out=%h expected=%h", key_out, 16'h0000); end
    tests++; if (pulses !== p0) begin fails++; $display("FAIL bounce_pulses: pulses=%0d expected=0", pulses - p0); end
  endtask

  task automatic test_multi_key();
    int p0;
    logic [15:0] exp_key;
`ifdef KEYPAD_ONEHOT_EN
    exp_key = 16'h0001;
`else
    exp_key = 16'h8001;
`endif
    p0 = pulses;
    repeat (DEB) run_scan(16'h8001);
    tests++; if (key_out !== exp_key) begin fails++; $display("FAIL multi_key: key_out=%h expected=%h", key_out, exp_key); end
    tests++; if (pulses - p0 !== 1) begin fails++; $display("FAIL multi_pulses: pulses=%0d expected=1", pulses - p0); end
    repeat (DEB) run_scan(16'h0000);
    tests++; if (key_out !== 16'h0000) begin fails++; $display("FAIL multi_release: key_out=%h expected=%h", key_out, 16'h0000); end
  endtask

  task automatic test_reset_mid();
    repeat (DEB) run_scan(16'h0020);
    tests++; if (key_out !== 16'h0020) begin fails++; $display("FAIL mid_pre: key_out=%h expected=%h", key_out, 16'h0020); end
    repeat (9) tick();
    tests++; if (row !== 4'b1011) begin fails++; $display("FAIL mid_row2: row_out=%b expected=%b", row, 4'b1011); end
    rst = 1'b1;
    tick();
    tests++; if (row !== 4'b1110) begin fails++; $display("FAIL mid_rst_row: row_out=%b expected=%b", row, 4'b1110); end
    tests++; if (key_out !== 16'h0000) begin fails++; $display("FAIL mid_rst_key: key_out=%h expected=%h", key_out, 16'h0000); end
    tests++; if (key_valid !== 1'b0) begin fails++; $display("FAIL mid_rst_valid: key_valid=%b expected=0", key_valid); end
    release_reset();
    run_scan(16'h0020);
    run_scan(16'h0020);
    tests++; if (key_out !== 16'h0000) begin fails++; $display("FAIL mid_early: key_out=%h expected=%h", key_out, 16'h0000); end
    run_scan(16'h0020);
    tests++; if (key_out !== 16'h0020) begin fails++; $display("FAIL mid_recommit: key_out=%h expected=%h", key_out, 16'h0020); end
    tests++; if (first_change !== DEB * SCAN + 1) begin fails++; $display("FAIL mid_latency: cycles=%0d expected=%0d", first_change, DEB * SCAN + 1); end
  endtask

  task automatic test_key_change();
    int p0;
    p0 = pulses;
    run_scan(16'h0040);
    run_scan(16'h0040);
    tests++; if (key_out !== 16'h0020) begin fails++; $display("FAIL change_early: key_out=%h expected=%h", key_out, 16'h0020); end
    run_scan(16'h0040);
    tests++; if (key_out !== 16'h0040) begin fails++; $display("FAIL change_commit: key_out=%h expected=%h", key_out, 16'h0040); end
    tests++; if (pulses - p0 !== 1) begin fails++; $display("FAIL change_pulses: pulses=%0d expected=1", pulses - p0); end
  endtask

  task automatic test_random();
    int p0, m0, run;
    logic [15:0] v;
    p0 = pulses;
    m0 = model_pulses;
    for (int n = 0; n < 25; n++) begin
      case ($urandom_range(0, 4))
        0: v = 16'h0000;
        1: v = 16'h0020;
        2: v = 16'h0040;
        3: v = 16'h8001;
        default: v = 16'($urandom());
      endcase
      run = int'($urandom_range(1, 5));
      for (int k = 0; k < run; k++) begin
        run_scan(v);
        tests++; if (key_out !== model_key) begin fails++; $display("FAIL random_key: scan %0d key_out=%h expected=%h", n, key_out, model_key); end
      end
    end
    tests++; if (pulses - p0 !== model_pulses - m0) begin fails++; $display("FAIL random_pulses: pulses=%0d expected=%0d", pulses - p0, model_pulses - m0); end
    tests++; if (seq_err !== 0) begin fails++; $display("FAIL valid_align: bad key_valid cycles=%0d expected=0", seq_err); end
    tests++; if (row_err !== 0) begin fails++; $display("FAIL row_total: bad row cycles=%0d expected=0", row_err); end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    tests        = 0;
    fails        = 0;
    cyc          = 0;
    pulses       = 0;
    seq_err      = 0;
    row_err      = 0;
    first_change = 0;
    prev_key     = 16'h0000;
    model_key    = 16'h0000;
    model_pulses = 0;
    pressed      = 16'h0000;
    rst          = 1'b1;
    test_reset();
    test_row_sequence();
    test_single_press();
    test_bounce();
    test_multi_key();
    test_reset_mid();
    test_key_change();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
